// File: rtl/dmem_block_ctrl.sv
// Line-granular backing memory below the data cache: serves one block read or write
// at a time after a fixed latency. Optional DMEM_STATS_EN adds read/write completion counters.
module dmem_block_ctrl #(
   parameter int line_size      = 32,
   parameter int block_size     = 2,
   parameter int address_size   = 32,
   parameter int mem_depth_log2 = 8,
   parameter int latency        = 4
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic                                  m_read_en_i,
   input  logic                                  m_wr_en_i,
   input  logic [address_size-block_size-3:0]    m_address_i,
   input  logic [(2**block_size)*line_size-1:0]  m_write_data_i,
   output logic [(2**block_size)*line_size-1:0]  m_read_data_o,
   output logic                                  m_busywait_o,
   output logic                                  m_read_done_o,
`ifdef DMEM_STATS_EN
   output logic                                  m_write_done_o,
   output logic [31:0]                           rd_count_o,
   output logic [31:0]                           wr_count_o
`else
   output logic                                  m_write_done_o
`endif
);

   // state   | meaning
   // IDLE    | waiting for a request; write wins over read
   // BUSY    | counting down latency; access commits on the terminal edge
   // RD_DONE | one-cycle read completion pulse
   // WR_DONE | one-cycle write completion pulse

   localparam int LW = (2**block_size)*line_size;
   localparam int AW = address_size-block_size-2;
   localparam int DEPTH = 2**mem_depth_log2;
   localparam logic [7:0] LAT_M1 = 8'(latency-1);

   typedef enum logic [1:0] {IDLE, BUSY, RD_DONE, WR_DONE} state_t;

   state_t                    state_q, state_d;
   logic [7:0]                count_q;
   logic [mem_depth_log2-1:0] addr_q;
   logic [LW-1:0]             data_q;
   logic                      op_wr_q;
   logic [LW-1:0]             mem [DEPTH];

   // Upper block-address bits alias onto the stored lines.
   logic addr_unused;
   assign addr_unused = ^m_address_i[AW-1:mem_depth_log2];

   always_comb begin
      state_d        = state_q;
      m_busywait_o   = 1'b0;
      m_read_done_o  = 1'b0;
      m_write_done_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (m_wr_en_i || m_read_en_i) state_d = BUSY;
         end
         BUSY: begin
            m_busywait_o = 1'b1;
            if (count_q == 8'd0) state_d = op_wr_q ? WR_DONE : RD_DONE;
         end
         RD_DONE: begin
            m_read_done_o = 1'b1;
            state_d       = IDLE;
         end
         WR_DONE: begin
            m_write_done_o = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= IDLE;
         count_q       <= 8'd0;
         addr_q        <= '0;
         data_q        <= '0;
         op_wr_q       <= 1'b0;
         m_read_data_o <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (m_wr_en_i) begin
                  addr_q  <= m_address_i[mem_depth_log2-1:0];
                  data_q  <= m_write_data_i;
                  op_wr_q <= 1'b1;
                  count_q <= LAT_M1;
               end else if (m_read_en_i) begin
                  addr_q  <= m_address_i[mem_depth_log2-1:0];
                  op_wr_q <= 1'b0;
                  count_q <= LAT_M1;
               end
            end
            BUSY: begin
               if (count_q == 8'd0) begin
                  if (op_wr_q) mem[addr_q] <= data_q;
                  else         m_read_data_o <= mem[addr_q];
               end else begin
                  count_q <= count_q - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DMEM_STATS_EN
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_count_o <= '0;
         wr_count_o <= '0;
      end else begin
         if (state_q != RD_DONE && state_d == RD_DONE) rd_count_o <= rd_count_o + 32'd1;
         if (state_q != WR_DONE && state_d == WR_DONE) wr_count_o <= wr_count_o + 32'd1;
      end
   end
`endif

endmodule

// File: doc/dmem_block_ctrl.md
Name: dmem_block_ctrl

Overview:
- Line-granular backing data memory that sits directly downstream of the data cache and serves its block refills and dirty write-backs.
- Accepts one block read or block write at a time, with a programmable fixed latency.
- Returns a one-cycle done pulse with busywait low, which is the completion condition the cache FSM waits on.
- Used as the main-memory model/controller under the RISC-V data cache in simulation and synthesis.

Parameters:
- line_size, 32, word width in bits.
- block_size, 2, log2 of words per line; a line is 2**block_size*line_size bits (128 at defaults).
- address_size, 32, byte address width; block address width is address_size-block_size-2 (28 at defaults).
- mem_depth_log2, 8, log2 of the number of stored lines.
- latency, 4, wait cycles per access; legal range 1..255.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- m_read_en_i  in  1  block read request, level, held until done
- m_wr_en_i  in  1  block write request, level, held until done
- m_address_i  in  address_size-block_size-2  block (line) address
- m_write_data_i  in  2**block_size*line_size  line to write
- m_read_data_o  out  2**block_size*line_size  line read
- m_busywait_o  out  1  access in progress
- m_read_done_o  out  1  one-cycle read completion pulse
- m_write_done_o  out  1  one-cycle write completion pulse

Behaviour:
- Storage: array of 2**mem_depth_log2 lines, indexed by m_address_i[mem_depth_log2-1:0]. Upper address bits are ignored, so addresses alias.
- Reset (async, active-high):
  - state=IDLE; counter=0.
  - All outputs 0, including m_read_data_o.
  - All array lines cleared to 0.
- FSM states: IDLE, BUSY, RD_DONE, WR_DONE.
- IDLE:
  - busywait=0, done outputs=0.
  - On a clock edge with m_wr_en_i=1: latch address, write data and op=write; counter=latency-1; go to BUSY.
  - Else if m_read_en_i=1: latch address and op=read; counter=latency-1; go to BUSY.
  - If both are high, the write wins. The read is served afterwards if it is still asserted.
- BUSY:
  - busywait=1.
  - Counter decrements each edge.
  - On the edge where counter==0: go to RD_DONE or WR_DONE.
  - Read: m_read_data_o <= array[latched index].
  - Write: array[latched index] <= latched data.
  - The write commits on this edge, not earlier.
- RD_DONE / WR_DONE:
  - busywait=0; m_read_done_o or m_write_done_o=1 for exactly this one cycle.
  - Next edge goes to IDLE unconditionally.
- Timing: a request sampled at edge E0 gives done high in the cycle after edge E_latency, and IDLE after E_latency+1.
  - Total turnaround is latency+2 cycles from request to next acceptance.
- Request changes after acceptance are ignored. Address and data are taken only from the latched copies.
- Request dropped mid-BUSY: the access still completes and done still pulses.
- m_read_data_o holds its value until the next read completes. Writes never change it.
- Write-then-read handshake: the cache asserts m_read_en_i in the cycle after WR_DONE. IDLE accepts it on that edge with no lost cycle.
- Reset asserted during BUSY: the access is aborted, an uncommitted write is discarded, and no done pulse is produced.

Optional Feature:
- Macro DMEM_STATS_EN.
- When defined: adds ports rd_count_o and wr_count_o (out, 32 bits each).
  - Each counter increments on entry to RD_DONE / WR_DONE respectively.
  - Counters wrap at 2**32 and reset to 0.
- When undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset, then read address 0x5 → m_read_data_o=0; m_read_done_o high exactly 5 edges after request (latency=4); busywait=1 for the 4 cycles before.
- Write 0x000000AA_000000BB_000000CC_000000DD to address 0x12, then read 0x12 → write_done pulses once; read returns the same 128-bit value.
- Write to 0x105 then read 0x005 (mem_depth_log2=8) → read returns the written data (aliasing).
- m_wr_en_i and m_read_en_i both high in IDLE → write completes first; read is accepted in the IDLE cycle after WR_DONE; two separate done pulses.
- Write 0x1 to address 0x3 with reset pulsed at the 2nd BUSY cycle → no done pulse; subsequent read of 0x3 returns 0.
- With DMEM_STATS_EN: 3 reads and 2 writes → rd_count_o=3, wr_count_o=2; both return to 0 after reset.
